// File: rtl/pix_fifo_pkg.sv
// Shared pixel types and elaboration helpers for the pixel FIFO slice.
package pix_fifo_pkg;

   typedef logic [11:0] pix_t;

   typedef struct packed {
      logic last;
      pix_t d;
   } pix_word_t;

   localparam int PIX_W  = $bits(pix_t);
   localparam int WORD_W = $bits(pix_word_t);

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/pix_sync_fifo_ptr.sv
// Wrap-bit pointer: AddrWidth address bits plus one MSB that toggles on each lap.
module fifo_ptr #(
   parameter int AddrWidth = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush_i,
   input  logic               inc_i,
   output logic [AddrWidth:0] ptr_o
);

   logic [AddrWidth:0] ptr_q;
   logic [AddrWidth:0] ptr_d;

   // Flush wins over an increment in the same cycle.
   always_comb begin
      ptr_d = ptr_q;
      if (flush_i) begin
         ptr_d = '0;
      end else if (inc_i) begin
         ptr_d = ptr_q + (AddrWidth + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/pix_sync_fifo.sv
// Single-clock first-word-fall-through pixel FIFO with end-of-line tag,
// fill level, almost-full watermark, sticky overflow and synchronous flush.
module pix_sync_fifo
   import pix_fifo_pkg::*;
#(
   parameter int Width         = PIX_W,
   parameter int Depth         = 16,
   parameter int AlmostFullThr = Depth - 2,
   parameter int AddrWidth     = $clog2(Depth)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               w,
   input  logic [Width-1:0]   wd,
   input  logic               wLast,
   output logic               wReady,
   input  logic               r,
   output logic [Width-1:0]   rd,
   output logic               rdLast,
   output logic               rdValid,
   output logic [AddrWidth:0] level,
   output logic               almostFull,
   output logic               overflow
);

   localparam logic [AddrWidth:0] AF_THR = (AddrWidth + 1)'(AlmostFullThr);

   generate
      if (Depth < 2 || !is_pow2(Depth)) begin : g_bad_depth
         $error("pix_sync_fifo: Depth must be a power of 2 and >= 2");
      end
      if (AddrWidth != $clog2(Depth)) begin : g_bad_addr
         $error("pix_sync_fifo: AddrWidth is derived from Depth and must not be overridden");
      end
      if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_bad_thr
         $error("pix_sync_fifo: AlmostFullThr must lie in 1..Depth");
      end
   endgenerate

   logic [AddrWidth:0]   wptr;
   logic [AddrWidth:0]   rptr;
   logic [AddrWidth-1:0] waddr;
   logic [AddrWidth-1:0] raddr;
   logic                 full;
   logic                 empty;
   logic                 wr_en;
   logic                 rd_en;
   logic [Width:0]       head;
   logic                 overflow_q;
   logic                 overflow_d;

   // Each entry holds {last, data}; no reset so the array maps onto LUT-RAM.
   logic [Width:0] mem_q [Depth];

   assign waddr = wptr[AddrWidth-1:0];
   assign raddr = rptr[AddrWidth-1:0];

   assign empty = (wptr == rptr);
   assign full  = (waddr == raddr) && (wptr[AddrWidth] != rptr[AddrWidth]);

   // Admission depends only on registered state, so a same-cycle read never frees room for a write.
   assign wr_en = w && !full && !flush;
   assign rd_en = r && !empty && !flush;

   fifo_ptr #(
      .AddrWidth (AddrWidth)
   ) u_wptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .inc_i   (wr_en),
      .ptr_o   (wptr)
   );

   fifo_ptr #(
      .AddrWidth (AddrWidth)
   ) u_rptr (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .inc_i   (rd_en),
      .ptr_o   (rptr)
   );

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[waddr] <= {wLast, wd};
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (flush) begin
         overflow_d = 1'b0;
      end else if (w && full) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   // Head is masked while empty so stale or uninitialised storage never reaches the outputs.
   assign head       = rdValid ? mem_q[raddr] : '0;
   assign rd         = head[Width-1:0];
   assign rdLast     = head[Width];
   assign rdValid    = !empty;
   assign wReady     = !full;
   assign level      = wptr - rptr;
   assign almostFull = (level >= AF_THR);
   assign overflow   = overflow_q;

endmodule
